// File: rtl/dmi_pkg.sv
// Shared DMI definitions: status codes returned to the DTM and responder FSM states.
package dmi_pkg;

  localparam logic [1:0] DMI_OK   = 2'b00;
  localparam logic [1:0] DMI_FAIL = 2'b10;
  localparam logic [1:0] DMI_BUSY = 2'b11;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  typedef enum logic {
    S_IDLE,
    S_BUS
  } dmi_state_e;

  // Busy/overrun outranks a failed access so the debugger retries before reading an error.
  function automatic logic [1:0] dmi_status(input logic busy, input logic overrun,
                                            input logic failed);
    if (busy || overrun) begin
      return DMI_BUSY;
    end
    if (failed) begin
      return DMI_FAIL;
    end
    return DMI_OK;
  endfunction

endpackage

// File: rtl/dmi_wb_responder.sv
// Core-side DMI responder: runs each DMI request as one Wishbone classic cycle and
// reports read data plus a sticky 2-bit status back to the DTM.
module dmi_wb_responder
  import dmi_pkg::*;
#(
  parameter int unsigned AWIDTH    = 7,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmi_reg_en,
  input  logic              dmi_reg_wr_en,
  input  logic [AWIDTH-1:0] dmi_reg_addr,
  input  logic [31:0]       dmi_reg_wdata,
  output logic [31:0]       dmi_reg_rdata,
  output logic [1:0]        rd_status,
  input  logic              dmi_hard_reset,
  output logic [31:0]       wb_adr_o,
  output logic [31:0]       wb_dat_o,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  dmi_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            overrun_q, overrun_d;
  logic            err_q, err_d;
  logic            cyc_q, cyc_d;
  logic            we_q, we_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      status_q, status_d;

  logic timeout_hit;
  logic bus_done;
  logic bus_fail;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TimeoutLast);
  assign bus_done    = wb_ack_i || wb_err_i || timeout_hit;
  // A timeout aborts like an error; err also wins over a simultaneous ack.
  assign bus_fail    = wb_err_i || !wb_ack_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    err_d     = err_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rdata_d   = rdata_q;

    if (dmi_hard_reset) begin
      state_d   = S_IDLE;
      cyc_d     = 1'b0;
      we_d      = 1'b0;
      overrun_d = 1'b0;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (dmi_reg_en) begin
            state_d = S_BUS;
            cyc_d   = 1'b1;
            we_d    = dmi_reg_wr_en;
            adr_d   = {BASE_ADDR[31:AWIDTH+2], dmi_reg_addr, 2'b00};
            dat_d   = dmi_reg_wdata;
            cnt_d   = '0;
          end
        end
        S_BUS: begin
          // Only one access may be outstanding; later requests are dropped and flagged.
          if (dmi_reg_en) begin
            overrun_d = 1'b1;
          end
          if (bus_done) begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            err_d   = bus_fail;
            if (!we_q) begin
              rdata_d = bus_fail ? 32'h0 : wb_dat_i;
            end
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
        end
      endcase
    end

    status_d = dmi_status(state_d == S_BUS, overrun_d, err_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= 32'h0;
      dat_q     <= 32'h0;
      rdata_q   <= 32'h0;
      status_q  <= DMI_OK;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
    end
  end

  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = WB_SEL_ALL;
  assign wb_we_o       = we_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign dmi_reg_rdata = rdata_q;
  assign rd_status     = status_q;

endmodule

// File: tb/tb_dmi_wb_responder.sv
// Directed bench for dmi_wb_responder: one instance with an 8-cycle timeout, one with none.
module tb_dmi_wb_responder;

  localparam logic [31:0] Base = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_en, a_hard, b_en, b_hard, wr, ack, err;
  logic [6:0]  addr;
  logic [31:0] wdata, dat_i;

  logic [31:0] a_rdata, a_adr, a_dat, b_rdata, b_adr, b_dat;
  logic [1:0]  a_status, b_status;
  logic [3:0]  a_sel, b_sel;
  logic        a_we, a_cyc, a_stb, b_we, b_cyc, b_stb;

  dmi_wb_responder #(.AWIDTH(7), .BASE_ADDR(Base), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .dmi_reg_en(a_en), .dmi_reg_wr_en(wr), .dmi_reg_addr(addr),
    .dmi_reg_wdata(wdata), .dmi_reg_rdata(a_rdata), .rd_status(a_status),
    .dmi_hard_reset(a_hard), .wb_adr_o(a_adr), .wb_dat_o(a_dat), .wb_sel_o(a_sel),
    .wb_we_o(a_we), .wb_cyc_o(a_cyc), .wb_stb_o(a_stb), .wb_dat_i(dat_i), .wb_ack_i(ack),
    .wb_err_i(err)
  );

  dmi_wb_responder #(.AWIDTH(7), .BASE_ADDR(Base), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .dmi_reg_en(b_en), .dmi_reg_wr_en(wr), .dmi_reg_addr(addr),
    .dmi_reg_wdata(wdata), .dmi_reg_rdata(b_rdata), .rd_status(b_status),
    .dmi_hard_reset(b_hard), .wb_adr_o(b_adr), .wb_dat_o(b_dat), .wb_sel_o(b_sel),
    .wb_we_o(b_we), .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_dat_i(dat_i), .wb_ack_i(ack),
    .wb_err_i(err)
  );

  // Transaction-level view: is an access outstanding, how long has it waited, what flags stick.
  typedef struct packed {
    logic        busy;
    logic        ovr;
    logic        err;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] adr;
    logic [31:0] dat;
    int unsigned waited;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, logic en, logic hard, int unsigned to);
    mdl_t n = m;
    logic fail;
    if (hard) begin
      n.busy = 1'b0;
      n.we   = 1'b0;
      n.ovr  = 1'b0;
      n.err  = 1'b0;
    end else if (!m.busy) begin
      if (en) begin
        n.busy   = 1'b1;
        n.we     = wr;
        n.adr    = (Base & ~32'h1FF) | ({25'b0, addr} << 2);
        n.dat    = wdata;
        n.waited = 0;
      end
    end else begin
      if (en) n.ovr = 1'b1;
      if (ack || err || (to != 0 && m.waited + 1 >= to)) begin
        fail   = err || !ack;
        n.busy = 1'b0;
        n.we   = 1'b0;
        n.err  = fail;
        if (!m.we) n.rdata = fail ? 32'h0 : dat_i;
      end else begin
        n.waited = m.waited + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [1:0] mdl_status(mdl_t m);
    if (m.busy || m.ovr) return 2'b11;
    if (m.err) return 2'b10;
    return 2'b00;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mdl_step(ma, a_en, a_hard, 8);
      mb <= mdl_step(mb, b_en, b_hard, 0);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_cyc", {31'b0, a_cyc}, {31'b0, ma.busy});
      chk("a_stb", {31'b0, a_stb}, {31'b0, ma.busy});
      chk("a_we", {31'b0, a_we}, {31'b0, ma.we});
      chk("a_sel", {28'b0, a_sel}, 32'hF);
      chk("a_adr", a_adr, ma.adr);
      chk("a_dat", a_dat, ma.dat);
      chk("a_rdata", a_rdata, ma.rdata);
      chk("a_status", {30'b0, a_status}, {30'b0, mdl_status(ma)});
      chk("b_cyc", {31'b0, b_cyc}, {31'b0, mb.busy});
      chk("b_adr", b_adr, mb.adr);
      chk("b_rdata", b_rdata, mb.rdata);
      chk("b_status", {30'b0, b_status}, {30'b0, mdl_status(mb)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic w, input logic [6:0] a, input logic [31:0] d);
    a_en  = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    tick();
    a_en  = 1'b0;
    wr    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    a_en = 0; a_hard = 0; b_en = 0; b_hard = 0; wr = 0; ack = 0; err = 0;
    addr = '0; wdata = '0; dat_i = '0;

    repeat (2) tick();
    chk("rst_cyc", {31'b0, a_cyc}, 32'h0);
    chk("rst_adr", a_adr, 32'h0);
    chk("rst_rdata", a_rdata, 32'h0);
    chk("rst_status", {30'b0, a_status}, 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Zero-wait read
    req_a(1'b0, 7'h10, 32'h0);
    chk("rd_adr", a_adr, 32'h8000_0040);
    chk("rd_stb", {31'b0, a_stb}, 32'h1);
    ack = 1'b1; dat_i = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0;
    chk("rd_stb_done", {31'b0, a_stb}, 32'h0);
    chk("rd_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("rd_status", {30'b0, a_status}, 32'h0);

    // Write with three wait states
    req_a(1'b1, 7'h01, 32'h1234_5678);
    chk("wr_we", {31'b0, a_we}, 32'h1);
    chk("wr_dat", a_dat, 32'h1234_5678);
    chk("wr_adr", a_adr, 32'h8000_0004);
    repeat (3) begin
      tick();
      chk("wr_busy", {30'b0, a_status}, 32'h3);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("wr_status", {30'b0, a_status}, 32'h0);
    chk("wr_rdata", a_rdata, 32'hDEAD_BEEF);

    // Error, good, ack+err, good
    req_a(1'b0, 7'h02, 32'h0);
    err = 1'b1;
    tick();
    err = 1'b0;
    chk("err_status", {30'b0, a_status}, 32'h2);
    chk("err_rdata", a_rdata, 32'h0);
    req_a(1'b0, 7'h03, 32'h0);
    ack = 1'b1; dat_i = 32'hCAFE_0001;
    tick();
    ack = 1'b0;
    chk("good_status", {30'b0, a_status}, 32'h0);
    chk("good_rdata", a_rdata, 32'hCAFE_0001);
    req_a(1'b0, 7'h04, 32'h0);
    ack = 1'b1; err = 1'b1; dat_i = 32'h5555_AAAA;
    tick();
    ack = 1'b0; err = 1'b0;
    chk("both_status", {30'b0, a_status}, 32'h2);
    chk("both_rdata", a_rdata, 32'h0);
    req_a(1'b0, 7'h05, 32'h0);
    ack = 1'b1; dat_i = 32'h0BAD_F00D;
    tick();
    ack = 1'b0;
    chk("rec_status", {30'b0, a_status}, 32'h0);
    chk("rec_rdata", a_rdata, 32'h0BAD_F00D);

    // Timeout of 8 cycles on a silent slave
    req_a(1'b0, 7'h06, 32'h0);
    n = 0;
    while (a_cyc && n < 50) begin
      n++;
      tick();
    end
    chk("to_cycles", n, 32'd8);
    chk("to_status", {30'b0, a_status}, 32'h2);

    // No timeout: cycle held for 1000 cycles until hard reset
    b_en = 1'b1; wr = 1'b0; addr = 7'h07;
    tick();
    b_en = 1'b0;
    repeat (1000) tick();
    chk("noto_cyc", {31'b0, b_cyc}, 32'h1);
    chk("noto_status", {30'b0, b_status}, 32'h3);
    b_hard = 1'b1;
    tick();
    b_hard = 1'b0;
    chk("noto_hr_cyc", {31'b0, b_cyc}, 32'h0);
    chk("noto_hr_status", {30'b0, b_status}, 32'h0);

    // Overrun: second request one cycle after the first
    req_a(1'b0, 7'h08, 32'h0);
    a_en = 1'b1;
    tick();
    a_en = 1'b0;
    tick();
    ack = 1'b1; dat_i = 32'h1111_2222;
    tick();
    ack = 1'b0;
    chk("ovr_cyc", {31'b0, a_cyc}, 32'h0);
    chk("ovr_status", {30'b0, a_status}, 32'h3);
    chk("ovr_rdata", a_rdata, 32'h1111_2222);
    repeat (3) tick();
    chk("ovr_no_second", {31'b0, a_cyc}, 32'h0);
    a_hard = 1'b1;
    tick();
    a_hard = 1'b0;
    chk("ovr_cleared", {30'b0, a_status}, 32'h0);

    // Hard reset coincident with ack discards the response
    req_a(1'b0, 7'h09, 32'h0);
    tick();
    a_hard = 1'b1; ack = 1'b1; dat_i = 32'hFFFF_FFFF;
    tick();
    a_hard = 1'b0; ack = 1'b0;
    chk("hr_cyc", {31'b0, a_cyc}, 32'h0);
    chk("hr_rdata", a_rdata, 32'h1111_2222);
    chk("hr_status", {30'b0, a_status}, 32'h0);

    // Asynchronous reset in the middle of a write cycle
    req_a(1'b1, 7'h0A, 32'hA5A5_A5A5);
    chk("ar_pre_cyc", {31'b0, a_cyc}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cyc", {31'b0, a_cyc}, 32'h0);
    chk("ar_stb", {31'b0, a_stb}, 32'h0);
    chk("ar_we", {31'b0, a_we}, 32'h0);
    chk("ar_adr", a_adr, 32'h0);
    chk("ar_dat", a_dat, 32'h0);
    chk("ar_rdata", a_rdata, 32'h0);
    chk("ar_status", {30'b0, a_status}, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("ar_idle", {31'b0, a_cyc}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
